nh_lcd_bus_responder: RTL
=========================

Name: nh_lcd_bus_responder

Overview:
Display-side end of the 8080-style parallel LCD bus driven by the nh_lcd controller. It oversamples cs_n/rs/write_n/read_n/data in the system clock domain and decodes write strobes into command, parameter and RGB888 pixel streams. It answers read strobes by driving io_data from a host-supplied byte. Used as a panel model in system benches and as the receive front end of a display bridge.

Parameters:
SYNC_STAGES, 2, synchronizer depth applied identically to all bus inputs including io_data (min 2)
MEM_WRITE, 8'h2C, command that opens a pixel stream and clears the pixel count
MEM_WRITE_CONT, 8'h3C, command that reopens a pixel stream and keeps the pixel count

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
i_cs_n  in  1  bus chip select, active-low
i_register_data_sel  in  1  bus RS: 0=command byte, 1=data byte
i_write_n  in  1  bus write strobe; byte latched on rising edge
i_read_n  in  1  bus read strobe, active-low
i_reset_n  in  1  bus display reset, active-low
io_data  inout  8  bus data
i_num_pixels  in  32  pixels per frame; 0 = unlimited
i_read_data  in  8  byte returned on bus reads
o_cmd_stb  out  1  one-cycle pulse: command byte received
o_cmd  out  8  last command byte, held
o_param_stb  out  1  one-cycle pulse: parameter byte received
o_param  out  8  parameter byte, held
o_param_index  out  8  index of o_param since last command
o_pixel_stb  out  1  one-cycle pulse: pixel complete
o_pixel  out  24  {R,G,B}, held
o_pixel_count  out  32  pixels received since last MEM_WRITE
o_frame_done  out  1  one-cycle pulse: o_pixel_count reached i_num_pixels
o_rd_stb  out  1  one-cycle pulse: bus read started
o_error  out  1  one-cycle pulse: protocol error

Behaviour:
- Reset (rst_n low, or synced i_reset_n low): state IDLE, every strobe 0, o_cmd/o_param/o_param_index/o_pixel/o_pixel_count 0, byte counter 0, io_data Z. A display reset mid-frame discards any partial pixel without o_error.
- Inputs pass through SYNC_STAGES flops; a write event is a synced write_n 0->1 while synced cs_n was low on the prior sample. Data is taken from the data sync stage aligned with write_n. Strobes assert SYNC_STAGES+1 clocks after the pin edge.
- Command (RS=0), from any state: o_cmd_stb, o_cmd updated. If byte==MEM_WRITE: state PIXEL, count=0, byte cnt=0. If MEM_WRITE_CONT: PIXEL, count kept. Else: state PARAM, o_param_index reset so the next param has index 0.
- Data in PARAM: o_param_stb, o_param=byte, index = params received so far (0,1,2..); index saturates at 255.
- Data in PIXEL: byte cnt 0=R, 1=G, 2=B. On B: o_pixel_stb, o_pixel={R,G,B}, count+1, byte cnt back to 0. If i_num_pixels!=0 and the new count == i_num_pixels: o_frame_done in the same cycle as o_pixel_stb, state IDLE.
- Data in IDLE: dropped, o_error.
- A command arriving while byte cnt !=0 in PIXEL: partial pixel discarded, o_error pulse with o_cmd_stb.
- Read: synced cs_n low and read_n low and write_n high -> io_data driven with i_read_data, sampled each clock. o_rd_stb on the synced falling edge. Drive releases SYNC_STAGES+1 clocks after read_n or cs_n rise. State unaffected by reads.
- Read and write both low: bus not driven, o_error once per overlap.
- o_pixel_count wraps at 2^32 without error.

Decomposition:
- nh_lcd_pkg: MEM_WRITE/MEM_WRITE_CONT defaults, state encoding (IDLE, PARAM, PIXEL), RS encoding.
- Sub-module nh_lcd_bus_sync: parameterised synchronizer plus rise/fall detect for the control pins and aligned data bus. Decoder FSM and tristate stay in the top.

Test Plan:
- Reset, then cmd 0x11, params 0x01,0x02 -> o_cmd_stb with 0x11; o_param_stb twice, index 0 then 1; no o_error.
- i_num_pixels=2, cmd 0x2C, data FF,00,80,01,02,03 -> pixels 24'hFF0080 then 24'h010203; o_frame_done with the second pixel; count=2; IDLE.
- Cmd 0x2C, 4 bytes, cmd 0x3C, 2 bytes -> o_error with o_cmd_stb; count stays 1; next pixel complete after byte 3 of new stream, count=2.
- i_read_data=8'hA5, read_n low for 8 clocks -> io_data=A5 from clock 3, o_rd_stb once, Z by 3 clocks after release.
- Data byte right after reset -> o_error, no o_param_stb/o_pixel_stb.
- i_reset_n low mid-pixel, then cmd 0x3C and 3 bytes -> outputs cleared; one pixel, count=1.

Source files
------------

// File: rtl/nh_lcd_pkg.sv
// Shared types and defaults for the nh_lcd parallel-bus responder.
package nh_lcd_pkg;

  localparam logic [7:0] MEM_WRITE_DEF      = 8'h2C;
  localparam logic [7:0] MEM_WRITE_CONT_DEF = 8'h3C;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARAM = 2'd1,
    ST_PIXEL = 2'd2
  } lcd_state_e;

  typedef struct packed {
    logic       cs_n;
    logic       rs;
    logic       write_n;
    logic       read_n;
    logic       reset_n;
    logic [7:0] data;
  } lcd_bus_t;

  // Quiescent bus: deselected, no strobes, display reset released.
  localparam lcd_bus_t BUS_IDLE = '{cs_n: 1'b1, rs: 1'b0, write_n: 1'b1,
                                    read_n: 1'b1, reset_n: 1'b1, data: 8'h00};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/nh_lcd_bus_sync.sv
// Synchronizes every bus pin through the same chain so data stays aligned
// with the strobes, and derives the write/read/overlap edge events.
module nh_lcd_bus_sync
  import nh_lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  lcd_bus_t bus_pin,
  output lcd_bus_t bus_cur,
  output logic     wr_evt,
  output logic     rd_fall,
  output logic     overlap_rise
);

  lcd_bus_t stg [SYNC_STAGES];
  logic     cs_prev, wr_prev, rd_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= BUS_IDLE;
      cs_prev <= 1'b1;
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
    end else begin
      stg[0] <= bus_pin;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      cs_prev <= stg[SYNC_STAGES-1].cs_n;
      wr_prev <= stg[SYNC_STAGES-1].write_n;
      rd_prev <= stg[SYNC_STAGES-1].read_n;
    end
  end

  assign bus_cur = stg[SYNC_STAGES-1];

  // Byte is latched on write_n rising while the chip was selected a sample earlier.
  assign wr_evt       = bus_cur.write_n & ~wr_prev & ~cs_prev;
  assign rd_fall      = ~bus_cur.read_n & rd_prev;
  assign overlap_rise = ~bus_cur.read_n & ~bus_cur.write_n & (rd_prev | wr_prev);

endmodule

// File: rtl/nh_lcd_bus_responder.sv
// Display-side 8080 bus responder: decodes commands, parameters and RGB888
// pixels from oversampled write strobes and answers reads from i_read_data.
module nh_lcd_bus_responder
  import nh_lcd_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [7:0] MEM_WRITE      = MEM_WRITE_DEF,
  parameter logic [7:0] MEM_WRITE_CONT = MEM_WRITE_CONT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cs_n,
  input  logic        i_register_data_sel,
  input  logic        i_write_n,
  input  logic        i_read_n,
  input  logic        i_reset_n,
  inout  wire  [7:0]  io_data,
  input  logic [31:0] i_num_pixels,
  input  logic [7:0]  i_read_data,
  output logic        o_cmd_stb,
  output logic [7:0]  o_cmd,
  output logic        o_param_stb,
  output logic [7:0]  o_param,
  output logic [7:0]  o_param_index,
  output logic        o_pixel_stb,
  output logic [23:0] o_pixel,
  output logic [31:0] o_pixel_count,
  output logic        o_frame_done,
  output logic        o_rd_stb,
  output logic        o_error
);

  lcd_bus_t   bus_pin, bus;
  logic       wr_evt, rd_fall, overlap_rise;
  lcd_state_e state_q, state_d;

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  red_q, red_d, grn_q, grn_d, param_n_q, param_n_d;
  logic [7:0]  cmd_d, param_d, param_idx_d;
  logic [23:0] pixel_d;
  logic [31:0] count_d, count_inc;
  logic        cmd_stb_d, param_stb_d, pixel_stb_d, frame_done_d, rd_stb_d, error_d;
  logic        disp_rst, cmd_wr, data_wr, frame_hit, pix_last;
  logic [7:0]  wr_byte;
  logic        drive_en_q;
  logic [7:0]  drive_data_q;

  assign bus_pin = '{cs_n: i_cs_n, rs: i_register_data_sel, write_n: i_write_n,
                     read_n: i_read_n, reset_n: i_reset_n, data: io_data};

  nh_lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_pin      (bus_pin),
    .bus_cur      (bus),
    .wr_evt       (wr_evt),
    .rd_fall      (rd_fall),
    .overlap_rise (overlap_rise)
  );

  assign disp_rst  = ~bus.reset_n;
  assign cmd_wr    = wr_evt & (bus.rs == RS_CMD);
  assign data_wr   = wr_evt & (bus.rs == RS_DATA);
  assign wr_byte   = bus.data;
  assign count_inc = o_pixel_count + 32'd1;
  assign frame_hit = (i_num_pixels != 32'd0) && (count_inc == i_num_pixels);
  assign pix_last  = (state_q == ST_PIXEL) && (byte_cnt_q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (disp_rst)
      state_d = ST_IDLE;
    else if (cmd_wr)
      state_d = (wr_byte == MEM_WRITE || wr_byte == MEM_WRITE_CONT) ? ST_PIXEL : ST_PARAM;
    else if (data_wr && pix_last && frame_hit)
      state_d = ST_IDLE;
  end

  always_comb begin
    cmd_stb_d    = 1'b0;
    param_stb_d  = 1'b0;
    pixel_stb_d  = 1'b0;
    frame_done_d = 1'b0;
    rd_stb_d     = rd_fall & ~bus.cs_n;
    error_d      = overlap_rise;
    cmd_d        = o_cmd;
    param_d      = o_param;
    param_idx_d  = o_param_index;
    pixel_d      = o_pixel;
    count_d      = o_pixel_count;
    byte_cnt_d   = byte_cnt_q;
    red_d        = red_q;
    grn_d        = grn_q;
    param_n_d    = param_n_q;
    if (cmd_wr) begin
      cmd_stb_d  = 1'b1;
      cmd_d      = wr_byte;
      byte_cnt_d = 2'd0;
      if (state_q == ST_PIXEL && byte_cnt_q != 2'd0) error_d = 1'b1;
      if (wr_byte == MEM_WRITE) begin
        count_d = 32'd0;
      end else if (wr_byte != MEM_WRITE_CONT) begin
        param_idx_d = 8'd0;
        param_n_d   = 8'd0;
      end
    end else if (data_wr) begin
      case (state_q)
        ST_PARAM: begin
          param_stb_d = 1'b1;
          param_d     = wr_byte;
          param_idx_d = param_n_q;
          param_n_d   = sat_inc8(param_n_q);
        end
        ST_PIXEL: begin
          case (byte_cnt_q)
            2'd0: begin red_d = wr_byte; byte_cnt_d = 2'd1; end
            2'd1: begin grn_d = wr_byte; byte_cnt_d = 2'd2; end
            default: begin
              pixel_stb_d  = 1'b1;
              pixel_d      = {red_q, grn_q, wr_byte};
              count_d      = count_inc;
              byte_cnt_d   = 2'd0;
              frame_done_d = frame_hit;
            end
          endcase
        end
        default: error_d = 1'b1;
      endcase
    end
    // Display reset wipes everything, including a partial pixel, silently.
    if (disp_rst) begin
      cmd_stb_d    = 1'b0;
      param_stb_d  = 1'b0;
      pixel_stb_d  = 1'b0;
      frame_done_d = 1'b0;
      rd_stb_d     = 1'b0;
      error_d      = 1'b0;
      cmd_d        = 8'd0;
      param_d      = 8'd0;
      param_idx_d  = 8'd0;
      pixel_d      = 24'd0;
      count_d      = 32'd0;
      byte_cnt_d   = 2'd0;
      red_d        = 8'd0;
      grn_d        = 8'd0;
      param_n_d    = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cmd_stb     <= 1'b0;
      o_param_stb   <= 1'b0;
      o_pixel_stb   <= 1'b0;
      o_frame_done  <= 1'b0;
      o_rd_stb      <= 1'b0;
      o_error       <= 1'b0;
      o_cmd         <= 8'd0;
      o_param       <= 8'd0;
      o_param_index <= 8'd0;
      o_pixel       <= 24'd0;
      o_pixel_count <= 32'd0;
      byte_cnt_q    <= 2'd0;
      red_q         <= 8'd0;
      grn_q         <= 8'd0;
      param_n_q     <= 8'd0;
      drive_en_q    <= 1'b0;
      drive_data_q  <= 8'd0;
    end else begin
      o_cmd_stb     <= cmd_stb_d;
      o_param_stb   <= param_stb_d;
      o_pixel_stb   <= pixel_stb_d;
      o_frame_done  <= frame_done_d;
      o_rd_stb      <= rd_stb_d;
      o_error       <= error_d;
      o_cmd         <= cmd_d;
      o_param       <= param_d;
      o_param_index <= param_idx_d;
      o_pixel       <= pixel_d;
      o_pixel_count <= count_d;
      byte_cnt_q    <= byte_cnt_d;
      red_q         <= red_d;
      grn_q         <= grn_d;
      param_n_q     <= param_n_d;
      // Never drive while write_n is low: that is a bus contention case.
      drive_en_q    <= ~disp_rst & ~bus.cs_n & ~bus.read_n & bus.write_n;
      drive_data_q  <= i_read_data;
    end
  end

  assign io_data = drive_en_q ? drive_data_q : 8'bz;

endmodule
